wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the pipelined MIPS core; consumes the MEM_WB pipeline register outputs and drives the register-file write port. Selects write data among ALU result, memory read data, return address, free-running cycle counter and a one-entry keyboard buffer. Also owns the frame-copy/clear engine behind the CopyToRAM and FrameFlush instructions, stalling the pipeline while it runs.

## Interface
- FrameWords, 512, words per frame copied or cleared; power of two, 2..4096.
- AddrBits, 9, width of buffer/VRAM word address; log2(FrameWords).

- CLK  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high.
- AluResult_In  in  32  ALU result from MEM_WB.
- MemData_In  in  32  RAM read data for this instruction.
- PC_plus_four_In  in  32  return address from MEM_WB.
- WAdr_In  in  5  destination register.
- RegWrite_In, MemToReg_In, JAL_In, Get_Cycles_In, KB_HIT_In  in  1 each  control bits from MEM_WB.
- CopyToRAM_In, FrameFlush_In  in  1 each  frame-engine requests from MEM_WB.
- KB_Valid  in  1  keyboard byte strobe.
- KB_Data  in  8  keyboard scan code.
- Buf_Data  in  32  screen-buffer read data, valid one cycle after Buf_Addr.
- RegWrite_Out  out  1  register-file write enable.
- WAdr_Out  out  5  register-file write address.
- WData_Out  out  32  register-file write data.
- KB_Ready  out  1  keyboard buffer empty.
- Buf_Addr  out  AddrBits  screen-buffer read address.
- VRAM_Addr  out  AddrBits  VRAM write address.
- VRAM_Data  out  32  VRAM write data.
- VRAM_We  out  1  VRAM write enable.
- Stall  out  1  pipeline freeze request.

## Operation
- Write data priority (combinational): JAL_In -> PC_plus_four_In; Get_Cycles_In -> cycle counter; KB_HIT_In -> {23'b0, kb_full, kb_byte}; MemToReg_In -> MemData_In; else AluResult_In.
- WAdr_Out = 31 when JAL_In, else WAdr_In.
- RegWrite_Out = (RegWrite_In | JAL_In) & (WAdr_Out != 0) & !Stall.
- Cycle counter: 32-bit, +1 every cycle, wraps 0xFFFFFFFF -> 0.
- Keyboard buffer: KB_Valid with kb_full=0 loads kb_byte, sets kb_full. KB_Valid while full and no read: byte dropped. KB_HIT read (RegWrite_Out=1) clears kb_full; same-cycle KB_Valid loads new byte and kb_full stays 1. KB_Ready = !kb_full.
- Frame engine states: IDLE, COPY, CLEAR.
  - IDLE: FrameFlush_In -> CLEAR (wins if both high); CopyToRAM_In -> COPY; index cleared to 0. Requests sampled only in IDLE.
  - COPY: Buf_Addr = index, index +1 per cycle for FrameWords cycles; VRAM_We=1, VRAM_Addr=Buf_Addr of previous cycle, VRAM_Data=Buf_Data, from 2nd through (FrameWords+1)th COPY cycle; then IDLE.
  - CLEAR: VRAM_We=1, VRAM_Addr=index, VRAM_Data=0 for FrameWords cycles; then IDLE.
- Stall = (state != IDLE).

## Timing
- Writeback path zero-latency (combinational from MEM_WB outputs).
- Reset values: state IDLE, index 0, cycle counter 0, kb_full 0, kb_byte 0; VRAM_We 0, Stall 0, Buf_Addr 0, VRAM_Addr 0, VRAM_Data 0, KB_Ready 1.
- Get_Cycles in first cycle after reset release returns 0.
- Copy: request at edge N; Stall high N+1..N+FrameWords+1; writes at VRAM_Addr 0..FrameWords-1. Clear: Stall high FrameWords cycles.
- Request instruction's own writeback occurs in request cycle (Stall still 0).
- Reset mid-operation: IDLE next edge; VRAM_We and Stall 0 immediately after that edge; no further writes.

## Configuration
- WB_FRAME_COPY_EN defined: frame engine as above.
- Undefined: engine removed; CopyToRAM_In/FrameFlush_In ignored; Stall, VRAM_We, Buf_Addr, VRAM_Addr, VRAM_Data tied 0. Writeback, counter and keyboard unchanged.

## Test plan
- Reset, then Get_Cycles_In=1, RegWrite_In=1, WAdr_In=8 on 5th cycle -> WData_Out=4, RegWrite_Out=1, WAdr_Out=8.
- JAL_In=1, PC_plus_four_In=0x00400010, WAdr_In=0 -> WAdr_Out=31, WData_Out=0x00400010, RegWrite_Out=1; RegWrite_In=1, WAdr_In=0, no JAL -> RegWrite_Out=0.
- KB_Valid with 0x1C, then 0x32 while full -> KB_HIT read returns 0x0000011C; next read returns 0x0000001C (kb_full=0); read + KB_Valid 0x29 same cycle -> kb_full stays 1, next read 0x00000129.
- FrameWords=8, CopyToRAM_In pulse, Buf_Data=0xA0+Buf_Addr -> Stall 9 cycles, VRAM writes addr k data 0xA0+k for k=0..7, RegWrite_Out 0 during Stall.
- FrameFlush_In and CopyToRAM_In same cycle -> CLEAR: 8 writes of 0, Stall 8 cycles; Reset asserted mid-clear at index 3 -> no writes after that edge, Stall 0.
- Build without WB_FRAME_COPY_EN, CopyToRAM_In=1 -> Stall 0, VRAM_We 0 throughout.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback mux, cycle counter, keyboard buffer, frame copy/clear engine.
// Optional frame engine enabled by defining WB_FRAME_COPY_EN.
module wb_stage #(
  parameter int FrameWords = 512,
  parameter int AddrBits   = 9
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [31:0]         AluResult_In,
  input  logic [31:0]         MemData_In,
  input  logic [31:0]         PC_plus_four_In,
  input  logic [4:0]          WAdr_In,
  input  logic                RegWrite_In,
  input  logic                MemToReg_In,
  input  logic                JAL_In,
  input  logic                Get_Cycles_In,
  input  logic                KB_HIT_In,
  input  logic                CopyToRAM_In,
  input  logic                FrameFlush_In,
  input  logic                KB_Valid,
  input  logic [7:0]          KB_Data,
  input  logic [31:0]         Buf_Data,
  output logic                RegWrite_Out,
  output logic [4:0]          WAdr_Out,
  output logic [31:0]         WData_Out,
  output logic                KB_Ready,
  output logic [AddrBits-1:0] Buf_Addr,
  output logic [AddrBits-1:0] VRAM_Addr,
  output logic [31:0]         VRAM_Data,
  output logic                VRAM_We,
  output logic                Stall
);

  logic [31:0] r_cycles;
  logic        r_kb_full;
  logic [7:0]  r_kb_byte;
  logic        w_kb_rd;

  // Writeback data select, highest priority first
  always_comb begin
    WData_Out = AluResult_In;
    if (JAL_In)
      WData_Out = PC_plus_four_In;
    else if (Get_Cycles_In)
      WData_Out = r_cycles;
    else if (KB_HIT_In)
      WData_Out = {23'b0, r_kb_full, r_kb_byte};
    else if (MemToReg_In)
      WData_Out = MemData_In;
  end

  assign WAdr_Out     = JAL_In ? 5'd31 : WAdr_In;
  assign RegWrite_Out = (RegWrite_In | JAL_In) & (WAdr_Out != 5'd0) & ~Stall;
  assign KB_Ready     = ~r_kb_full;
  assign w_kb_rd      = KB_HIT_In & RegWrite_Out;

  // Free-running cycle counter
  always_ff @(posedge CLK) begin
    if (Reset) r_cycles <= 32'd0;
    else       r_cycles <= r_cycles + 32'd1;
  end

  // One-entry keyboard buffer; a read frees the slot for a same-cycle byte
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_kb_full <= 1'b0;
      r_kb_byte <= 8'd0;
    end else if (w_kb_rd) begin
      r_kb_full <= KB_Valid;
      if (KB_Valid) r_kb_byte <= KB_Data;
    end else if (KB_Valid && !r_kb_full) begin
      r_kb_full <= 1'b1;
      r_kb_byte <= KB_Data;
    end
  end

`ifdef WB_FRAME_COPY_EN
  typedef enum logic [1:0] {S_IDLE, S_COPY, S_CLEAR} state_t;

  localparam logic [AddrBits:0] C_FW    = (AddrBits+1)'(FrameWords);
  localparam logic [AddrBits:0] C_FW_M1 = C_FW - 1'b1;

  state_t              r_state, w_state_nx;
  logic [AddrBits:0]   r_idx, w_idx_nx;
  logic [AddrBits:0]   w_idx_m1;

  assign w_idx_m1 = r_idx - 1'b1;
  assign Stall    = (r_state != S_IDLE);

  // Engine state and word index
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
    end
  end

  // Next state and buffer/VRAM port drive; copy writes lag reads by one cycle
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    Buf_Addr   = '0;
    VRAM_Addr  = '0;
    VRAM_Data  = 32'd0;
    VRAM_We    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idx_nx = '0;
        if (FrameFlush_In)     w_state_nx = S_CLEAR;
        else if (CopyToRAM_In) w_state_nx = S_COPY;
      end
      S_COPY: begin
        Buf_Addr = r_idx[AddrBits-1:0];
        w_idx_nx = r_idx + 1'b1;
        if (r_idx != '0) begin
          VRAM_We   = 1'b1;
          VRAM_Addr = w_idx_m1[AddrBits-1:0];
          VRAM_Data = Buf_Data;
        end
        if (r_idx == C_FW) begin
          w_state_nx = S_IDLE;
          w_idx_nx   = '0;
        end
      end
      S_CLEAR: begin
        VRAM_We   = 1'b1;
        VRAM_Addr = r_idx[AddrBits-1:0];
        w_idx_nx  = r_idx + 1'b1;
        if (r_idx == C_FW_M1) begin
          w_state_nx = S_IDLE;
          w_idx_nx   = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_idx_nx   = '0;
      end
    endcase
  end
`else
  logic w_unused;

  assign w_unused  = ^{CopyToRAM_In, FrameFlush_In, Buf_Data};
  assign Stall     = 1'b0;
  assign VRAM_We   = 1'b0;
  assign Buf_Addr  = '0;
  assign VRAM_Addr = '0;
  assign VRAM_Data = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vectors, keyboard/counter sequences, random model check,
// and frame engine sequences (WB_FRAME_COPY_EN) or their absence.
module tb_wb_stage;
  localparam int FW = 8;
  localparam int AW = 3;

  logic          CLK;
  logic          Reset;
  logic [31:0]   AluResult_In, MemData_In, PC_plus_four_In;
  logic [4:0]    WAdr_In;
  logic          RegWrite_In, MemToReg_In, JAL_In;
  logic          Get_Cycles_In, KB_HIT_In;
  logic          CopyToRAM_In, FrameFlush_In;
  logic          KB_Valid;
  logic [7:0]    KB_Data;
  logic [31:0]   Buf_Data;
  logic          RegWrite_Out;
  logic [4:0]    WAdr_Out;
  logic [31:0]   WData_Out;
  logic          KB_Ready;
  logic [AW-1:0] Buf_Addr, VRAM_Addr;
  logic [31:0]   VRAM_Data;
  logic          VRAM_We, Stall;

  wb_stage #(.FrameWords(FW), .AddrBits(AW)) dut (
    .CLK(CLK), .Reset(Reset),
    .AluResult_In(AluResult_In), .MemData_In(MemData_In),
    .PC_plus_four_In(PC_plus_four_In), .WAdr_In(WAdr_In),
    .RegWrite_In(RegWrite_In), .MemToReg_In(MemToReg_In),
    .JAL_In(JAL_In), .Get_Cycles_In(Get_Cycles_In),
    .KB_HIT_In(KB_HIT_In), .CopyToRAM_In(CopyToRAM_In),
    .FrameFlush_In(FrameFlush_In), .KB_Valid(KB_Valid),
    .KB_Data(KB_Data), .Buf_Data(Buf_Data),
    .RegWrite_Out(RegWrite_Out), .WAdr_Out(WAdr_Out),
    .WData_Out(WData_Out), .KB_Ready(KB_Ready),
    .Buf_Addr(Buf_Addr), .VRAM_Addr(VRAM_Addr),
    .VRAM_Data(VRAM_Data), .VRAM_We(VRAM_We), .Stall(Stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Screen buffer with one-cycle read latency
  always @(posedge CLK) Buf_Data <= 32'hA0 + 32'(Buf_Addr);

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: cycles since reset, keyboard slot
  int unsigned m_cyc;
  bit          m_full;
  logic [7:0]  m_byte;

  // Per-cycle snapshot taken at the negedge
  logic          s_stall, s_we, s_rw;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_data;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] e_adr();
    return JAL_In ? 5'd31 : WAdr_In;
  endfunction

  function automatic logic e_we(input bit stalled);
    return (RegWrite_In || JAL_In) && (e_adr() != 0) && !stalled;
  endfunction

  function automatic logic [31:0] e_data();
    if (JAL_In)        return PC_plus_four_In;
    if (Get_Cycles_In) return m_cyc;
    if (KB_HIT_In)     return {23'b0, m_full, m_byte};
    if (MemToReg_In)   return MemData_In;
    return AluResult_In;
  endfunction

  // One clock: optionally compare against the model, then advance the model
  task automatic step(input bit do_chk);
    bit rd;
    @(negedge CLK);
    s_stall = Stall; s_we = VRAM_We; s_addr = VRAM_Addr;
    s_data = VRAM_Data; s_rw = RegWrite_Out;
    if (do_chk) begin
      chk("wdata", WData_Out, e_data());
      chk("wadr", {27'b0, WAdr_Out}, {27'b0, e_adr()});
      chk("regwrite", {31'b0, RegWrite_Out}, {31'b0, e_we(0)});
      chk("kb_ready", {31'b0, KB_Ready}, {31'b0, !m_full});
      chk("stall", {31'b0, Stall}, 32'd0);
    end
    rd = KB_HIT_In && e_we(Stall);
    if (Reset) begin
      m_cyc = 0; m_full = 0; m_byte = 8'd0;
    end else begin
      m_cyc++;
      if (rd) begin
        m_full = KB_Valid;
        if (KB_Valid) m_byte = KB_Data;
      end else if (KB_Valid && !m_full) begin
        m_full = 1; m_byte = KB_Data;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    AluResult_In = 0; MemData_In = 0; PC_plus_four_In = 0; WAdr_In = 0;
    RegWrite_In = 0; MemToReg_In = 0; JAL_In = 0; Get_Cycles_In = 0;
    KB_HIT_In = 0; CopyToRAM_In = 0; FrameFlush_In = 0;
    KB_Valid = 0; KB_Data = 0;
  endtask

  typedef struct {
    bit          jal, mtr, rw;
    logic [4:0]  adr;
    logic [31:0] alu, mem, pc;
    bit          x_we;
    logic [4:0]  x_adr;
    logic [31:0] x_data;
  } vec_t;

  vec_t vt[6];

  initial begin
    int st, nw, bad;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    vt[0] = '{0,0,1,5'd5, 32'h12345678,32'hDEADBEEF,32'h400, 1,5'd5, 32'h12345678};
    vt[1] = '{0,1,1,5'd5, 32'h12345678,32'hDEADBEEF,32'h400, 1,5'd5, 32'hDEADBEEF};
    vt[2] = '{1,0,0,5'd0, 32'h1,32'h2,32'h00400010, 1,5'd31, 32'h00400010};
    vt[3] = '{0,0,1,5'd0, 32'hCAFE0001,32'h2,32'h3, 0,5'd0, 32'hCAFE0001};
    vt[4] = '{1,1,1,5'd7, 32'h1,32'h2,32'h00400abc, 1,5'd31, 32'h00400abc};
    vt[5] = '{0,0,0,5'd9, 32'h77,32'h88,32'h99, 0,5'd9, 32'h77};

    idle_in();
    Reset = 1;
    m_cyc = 0; m_full = 0; m_byte = 0;
    step(0); step(0);
    @(negedge CLK);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_vwe", {31'b0, VRAM_We}, 32'd0);
    chk("rst_baddr", 32'(Buf_Addr), 32'd0);
    chk("rst_vaddr", 32'(VRAM_Addr), 32'd0);
    chk("rst_vdata", VRAM_Data, 32'd0);
    chk("rst_kbrdy", {31'b0, KB_Ready}, 32'd1);
    @(posedge CLK); #1;
    Reset = 0;

    for (int i = 0; i < 4; i++) step(0);
    Get_Cycles_In = 1; RegWrite_In = 1; WAdr_In = 8;
    #1;
    chk("cyc5_data", WData_Out, 32'd4);
    chk("cyc5_we", {31'b0, RegWrite_Out}, 32'd1);
    chk("cyc5_adr", {27'b0, WAdr_Out}, 32'd8);
    step(1);
    idle_in();

    for (int i = 0; i < 6; i++) begin
      JAL_In = vt[i].jal; MemToReg_In = vt[i].mtr; RegWrite_In = vt[i].rw;
      WAdr_In = vt[i].adr; AluResult_In = vt[i].alu;
      MemData_In = vt[i].mem; PC_plus_four_In = vt[i].pc;
      #1;
      chk("vec_we", {31'b0, RegWrite_Out}, {31'b0, vt[i].x_we});
      chk("vec_adr", {27'b0, WAdr_Out}, {27'b0, vt[i].x_adr});
      chk("vec_data", WData_Out, vt[i].x_data);
      step(1);
    end
    idle_in();

    KB_Valid = 1; KB_Data = 8'h1C; step(1);
    KB_Data = 8'h32; step(1);
    KB_Valid = 0; KB_HIT_In = 1; RegWrite_In = 1; WAdr_In = 2;
    #1; chk("kb_read1", WData_Out, 32'h0000011C);
    step(1);
    #1; chk("kb_read2", WData_Out, 32'h0000001C);
    step(1);
    KB_Valid = 1; KB_Data = 8'h29; step(1);
    KB_Valid = 0;
    #1; chk("kb_read3", WData_Out, 32'h00000129);
    chk("kb_full3", {31'b0, KB_Ready}, 32'd0);
    step(1);
    idle_in();

    for (int i = 0; i < 300; i++) begin
      JAL_In = ($urandom_range(7) == 0);
      Get_Cycles_In = ($urandom_range(5) == 0);
      KB_HIT_In = ($urandom_range(3) == 0);
      MemToReg_In = $urandom_range(1);
      RegWrite_In = ($urandom_range(3) != 0);
      WAdr_In = 5'($urandom_range(31));
      AluResult_In = $urandom; MemData_In = $urandom;
      PC_plus_four_In = $urandom;
      KB_Valid = ($urandom_range(2) == 0);
      KB_Data = 8'($urandom_range(255));
      step(1);
    end
    idle_in();

`ifdef WB_FRAME_COPY_EN
    CopyToRAM_In = 1; RegWrite_In = 1; WAdr_In = 3; AluResult_In = 32'h55;
    #1; chk("req_wb_we", {31'b0, RegWrite_Out}, 32'd1);
    step(0);
    CopyToRAM_In = 0; WAdr_In = 4;
    st = 0; bad = 0; wa.delete(); wd.delete();
    for (int i = 0; i < 30; i++) begin
      step(0);
      if (s_stall) st++;
      if (s_stall && s_rw) bad++;
      if (s_we) begin wa.push_back(s_addr); wd.push_back(s_data); end
      if (!s_stall) break;
    end
    chk("copy_stall", st, 9);
    chk("copy_nw", wa.size(), FW);
    chk("copy_rw_blk", bad, 0);
    for (int k = 0; k < wa.size(); k++) begin
      chk("copy_addr", 32'(wa[k]), k);
      chk("copy_data", wd[k], 32'hA0 + k);
    end
    idle_in();

    FrameFlush_In = 1; CopyToRAM_In = 1; step(0);
    idle_in();
    st = 0; wa.delete(); wd.delete();
    for (int i = 0; i < 30; i++) begin
      step(0);
      if (s_stall) st++;
      if (s_we) begin wa.push_back(s_addr); wd.push_back(s_data); end
      if (!s_stall) break;
    end
    chk("clr_stall", st, FW);
    chk("clr_nw", wa.size(), FW);
    for (int k = 0; k < wa.size(); k++) begin
      chk("clr_addr", 32'(wa[k]), k);
      chk("clr_data", wd[k], 32'd0);
    end

    FrameFlush_In = 1; step(0);
    FrameFlush_In = 0;
    for (int i = 0; i < 3; i++) step(0);
    Reset = 1; step(0);
    chk("rst_mid_we", {31'b0, s_we}, 32'd1);
    chk("rst_mid_addr", 32'(s_addr), 32'd3);
    Reset = 0;
    nw = 0; st = 0;
    for (int i = 0; i < 12; i++) begin
      step(0);
      if (s_we) nw++;
      if (s_stall) st++;
    end
    chk("rst_after_we", nw, 0);
    chk("rst_after_stall", st, 0);
`else
    CopyToRAM_In = 1;
    nw = 0; st = 0;
    for (int i = 0; i < 12; i++) begin
      FrameFlush_In = (i >= 6);
      step(0);
      if (s_we) nw++;
      if (s_stall) st++;
    end
    chk("nofe_we", nw, 0);
    chk("nofe_stall", st, 0);
    idle_in();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
